dmem_sram_bridge: RTL
=====================

Name: dmem_sram_bridge

Overview:
- Responder for the CPU core's data-memory port: mem_en, mem_we, sel, mem_size, address, write data and mem_rdata, plus the stallreq_from_mem back-pressure.
- Converts each accepted CPU access into one transaction on an sram-like bus (req/addr_ok/data_ok).
- Holds the MEM stage stalled until the transaction completes, then returns read data for one release cycle.
- Sits between the datapath's MEM stage and the data-side bus/crossbar.

Parameters:
- ADDR_MAP, 1, 1 = fold kseg0/kseg1 virtual addresses (cpu_addr[31:30]==2'b10) to physical {3'b000, cpu_addr[28:0]}; 0 = pass the address through unchanged.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- cpu_en  in  1  MEM-stage access request (mem_en)
- cpu_we  in  1  1 = store, 0 = load
- cpu_sel  in  4  byte enables for stores
- cpu_size  in  2  00 byte, 01 half, 10 word
- cpu_addr  in  32  virtual byte address (MEM-stage ALU result)
- cpu_wdata  in  32  store data, already byte-lane aligned
- cpu_flush  in  1  MEM-stage flush (exception/eret)
- cpu_rdata  out  32  load data, valid in the release cycle
- cpu_stall  out  1  stallreq_from_mem
- bus_req  out  1  bus request valid
- bus_wr  out  1  1 = write
- bus_size  out  2  copy of cpu_size
- bus_addr  out  32  physical address
- bus_wstrb  out  4  byte strobes; 0 on reads
- bus_wdata  out  32  write data
- bus_addr_ok  in  1  request accepted this cycle
- bus_data_ok  in  1  response (read data / write ack) this cycle
- bus_rdata  in  32  read data, valid with bus_data_ok

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, cancel=0.
  - bus_req, bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata = 0.
  - cpu_rdata = 0.
  - Reset mid-transaction abandons it immediately. addr_ok/data_ok arriving in IDLE or DONE are ignored.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If cpu_en & ~cpu_flush: latch the bus fields, bus_req<=1, go to REQ.
  - Latched fields: bus_addr = mapped cpu_addr, bus_wr = cpu_we, bus_size = cpu_size, bus_wstrb = cpu_we ? cpu_sel : 0, bus_wdata = cpu_wdata.
  - Otherwise stay in IDLE.
- REQ:
  - bus_req is held high and all bus fields stay stable until bus_addr_ok.
  - On addr_ok: bus_req<=0.
  - addr_ok & data_ok in the same cycle: go to DONE, or to IDLE if cancel.
  - addr_ok alone: go to WAIT.
- WAIT: on data_ok go to DONE, or to IDLE if cancel. Reads capture bus_rdata into cpu_rdata; writes leave cpu_rdata unchanged.
- DONE: one cycle, cpu_stall=0, then go to IDLE. No new request is issued in DONE: the same instruction is still in MEM and leaves at this edge.
- cpu_stall (combinational): (IDLE & cpu_en & ~cpu_flush) | REQ | WAIT.
- Latency: an access with addr_ok on its first REQ cycle and data_ok N cycles later (N≥0) stalls for 2+N cycles, then releases in DONE. Zero-wait access: IDLE(stall), REQ(stall, addr_ok+data_ok), DONE(release) = 2 stall cycles.
- Flush:
  - cpu_flush in IDLE suppresses the request.
  - cpu_flush in REQ/WAIT sets cancel. The bus transaction still completes, because a request is never withdrawn before addr_ok.
  - cpu_stall stays high until completion; completion then goes to IDLE with cpu_rdata unchanged.
  - cancel clears on entering IDLE.
- cpu_* inputs are sampled only in IDLE. Changes during REQ/WAIT have no effect.
- Misaligned or size/sel inconsistencies are not checked here; the exception is raised upstream and arrives as cpu_flush.

Test Plan:
- Word load, addr 0x8000_1004, ADDR_MAP=1; addr_ok on first REQ cycle, data_ok 2 cycles later with 0xDEADBEEF -> bus_addr=0x0000_1004, bus_wstrb=0, cpu_stall high 4 cycles, DONE cycle cpu_rdata=0xDEADBEEF with stall low, no second bus_req.
- Byte store, addr 0xA000_0003, sel=4'b1000, wdata=0x5500_0000; addr_ok and data_ok same cycle -> bus_wr=1, bus_wstrb=1000, bus_addr=0x0000_0003, stall 2 cycles, cpu_rdata unchanged.
- addr_ok withheld 5 cycles while cpu_addr toggles -> bus_req and bus_addr stable all 5 cycles; stall held until data_ok.
- cpu_flush pulsed during WAIT of a load -> stall held until data_ok, then IDLE with no DONE cycle; cpu_rdata keeps its prior value. cpu_flush with cpu_en in IDLE -> no bus_req, stall=0.
- rst asserted in WAIT -> next cycle state IDLE, bus_req=0, cpu_rdata=0; a stray data_ok afterwards is ignored.
- Back-to-back loads in consecutive instructions, ADDR_MAP=0, addr 0x1FC0_0000 -> bus_addr passed through unchanged; exactly one bus_req per access, with one DONE release cycle between them.

Source files
------------

// File: rtl/dmem_sram_bridge.sv
// Data-memory bridge: turns each accepted MEM-stage access into one sram-like
// bus transaction and stalls the pipeline until that transaction completes.
module dmem_sram_bridge #(
  parameter int ADDR_MAP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_en,
  input  logic        cpu_we,
  input  logic [3:0]  cpu_sel,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_flush,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_reg;
  logic        cancel_reg;
  logic        accept;
  logic        abort_now;
  logic [31:0] mapped_addr;

  // kseg0/kseg1 both alias the low 512 MB of physical memory.
  always_comb begin
    mapped_addr = cpu_addr;
    if ((ADDR_MAP != 0) && (cpu_addr[31:30] == 2'b10)) begin
      mapped_addr = {3'b000, cpu_addr[28:0]};
    end
  end

  assign accept    = (state_reg == IDLE) && cpu_en && !cpu_flush;
  // A flush arriving in the completion cycle itself also drops the result.
  assign abort_now = cancel_reg || cpu_flush;
  assign cpu_stall = accept || (state_reg == REQ) || (state_reg == WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cancel_reg <= 1'b0;
      bus_req    <= 1'b0;
      bus_wr     <= 1'b0;
      bus_size   <= 2'b00;
      bus_addr   <= 32'h0;
      bus_wstrb  <= 4'h0;
      bus_wdata  <= 32'h0;
      cpu_rdata  <= 32'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          cancel_reg <= 1'b0;
          if (accept) begin
            bus_req   <= 1'b1;
            bus_wr    <= cpu_we;
            bus_size  <= cpu_size;
            bus_addr  <= mapped_addr;
            bus_wstrb <= cpu_we ? cpu_sel : 4'h0;
            bus_wdata <= cpu_wdata;
            state_reg <= REQ;
          end
        end
        REQ: begin
          if (cpu_flush) begin
            cancel_reg <= 1'b1;
          end
          // The request is never withdrawn before addr_ok, even when cancelled.
          if (bus_addr_ok) begin
            bus_req <= 1'b0;
            if (bus_data_ok) begin
              if (abort_now) begin
                state_reg  <= IDLE;
                cancel_reg <= 1'b0;
              end else begin
                state_reg <= DONE;
                if (!bus_wr) begin
                  cpu_rdata <= bus_rdata;
                end
              end
            end else begin
              state_reg <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cpu_flush) begin
            cancel_reg <= 1'b1;
          end
          if (bus_data_ok) begin
            if (abort_now) begin
              state_reg  <= IDLE;
              cancel_reg <= 1'b0;
            end else begin
              state_reg <= DONE;
              if (!bus_wr) begin
                cpu_rdata <= bus_rdata;
              end
            end
          end
        end
        DONE: begin
          // Release cycle: the instruction leaves MEM at this edge.
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
